// File: rtl/fetch_decode_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_if
//   Instruction-memory fetch bus between fetch_decode (master) and the
//   instruction memory (slave). One word is transferred on every cycle in which
//   imem_req and imem_ack are both high; the memory may stretch a fetch with
//   any number of wait states by holding imem_ack low.
//
//   Signals:
//     imem_addr  [NBITS-1:0]  byte address of the fetch (master -> slave)
//     imem_req                fetch request               (master -> slave)
//     imem_ack                imem_rdata valid this cycle (slave -> master)
//     imem_rdata [31:0]       instruction word            (slave -> master)
// -----------------------------------------------------------------------------
interface fetch_decode_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] imem_addr;
    logic             imem_req;
    logic             imem_ack;
    logic [31:0]      imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
//   Fetch/decode stage of the single-issue RV32I-subset datapath. Holds the PC,
//   fetches one instruction word per instruction over the imem bus, latches it
//   into IR and drives the datapath controls for exactly one EXEC cycle.
//   Computes link value and next PC for JAL / JALR / BEQ.
//
//   Supported: ADD, SUB, ADDI, JAL, JALR, BEQ. Everything else is illegal.
//
//   Build option:
//     FETCH_HALT_ON_ILLEGAL_EN  defined   -> illegal instruction enters HALT
//                               undefined -> illegal instruction is a NOP
//
//   Ports:
//     clock, reset      rising-edge clock, synchronous active-high reset
//     imem              fetch bus (master side)
//     RS1, RS2, RD      register indices (RD forced to 0 outside EXEC)
//     IMM               sign-extended immediate truncated to NBITS
//     ALUControl        0000 add, 1000 sub
//     ALUSrc, MemtoReg, RegWrite, link   datapath controls (0 outside EXEC)
//     pclink            PC+4, written to RD when link is high
//     PCReg, Zero       rs1 value and ALU zero flag, sampled at EXEC close
//     halted            stage stopped on an illegal instruction
//     instret           retired instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_decode #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    fetch_decode_if.master               imem,
    output logic [$clog2(NREGS)-1:0]     RS1,
    output logic [$clog2(NREGS)-1:0]     RS2,
    output logic [$clog2(NREGS)-1:0]     RD,
    output logic signed [NBITS-1:0]      IMM,
    output logic [WIDTH_ALUF-1:0]        ALUControl,
    output logic                         ALUSrc,
    output logic                         MemtoReg,
    output logic                         RegWrite,
    output logic                         link,
    output logic [NBITS-1:0]             pclink,
    input  logic [NBITS-1:0]             PCReg,
    input  logic                         Zero,
    output logic                         halted,
    output logic [NBITS-1:0]             instret
);
    localparam int RW = $clog2(NREGS);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [WIDTH_ALUF-1:0] ALU_ADD = '0;
    localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(4'b1000);

    // Sign-extended 32-bit immediate reduced to the datapath width.
    function automatic logic signed [NBITS-1:0] trunc_imm(input logic signed [31:0] v);
        return v[NBITS-1:0];
    endfunction

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [NBITS-1:0] instret_q, instret_d;

    // ---- decode of IR ----
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_add, is_sub, is_addi, is_jal, is_jalr, is_beq, legal;
    logic signed [NBITS-1:0] imm_i, imm_j, imm_b;
    logic [NBITS-1:0] pc_plus4, jalr_sum;
    logic       exec_active;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_jal  = (opcode == 7'b1101111);
    assign is_jalr = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign legal   = is_add | is_sub | is_addi | is_jal | is_jalr | is_beq;

    assign imm_i = trunc_imm({{20{ir_q[31]}}, ir_q[31:20]});
    assign imm_j = trunc_imm({{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0});
    assign imm_b = trunc_imm({{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0});

    assign pc_plus4 = pc_q + NBITS'(32'd4);
    assign jalr_sum = PCReg + $unsigned(imm_i);

    // Controls are only live during EXEC; reset masks them immediately so the
    // datapath sees no write in the cycle reset is raised.
    assign exec_active = (state_q == S_EXEC) && !reset;

    // ---- outputs ----
    assign imem.imem_req  = (state_q == S_FETCH) && !reset;
    assign imem.imem_addr = pc_q;

    assign RS1 = ir_q[15 +: RW];
    assign RS2 = ir_q[20 +: RW];
    assign RD  = exec_active ? ir_q[7 +: RW] : '0;
    assign IMM = is_jal ? imm_j : (is_beq ? imm_b : imm_i);

    assign ALUControl = (exec_active && (is_sub || is_beq)) ? ALU_SUB : ALU_ADD;
    assign ALUSrc     = exec_active && is_addi;
    assign MemtoReg   = 1'b0;
    assign RegWrite   = exec_active && (is_add || is_sub || is_addi || is_jal || is_jalr);
    assign link       = exec_active && (is_jal || is_jalr);
    assign pclink     = pc_plus4;

    assign halted  = (state_q == S_HALT);
    assign instret = instret_q;

    // ---- next state ----
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (legal) begin
                    if (is_jal)
                        pc_d = pc_q + $unsigned(imm_j);
                    else if (is_jalr)
                        pc_d = {jalr_sum[NBITS-1:1], 1'b0};
                    else if (is_beq && Zero)
                        pc_d = pc_q + $unsigned(imm_b);
                    else
                        pc_d = pc_plus4;
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
                end else begin
`ifdef FETCH_HALT_ON_ILLEGAL_EN
                    state_d = S_HALT;
`else
                    pc_d      = pc_plus4;
                    instret_d = instret_q + 1'b1;
                    state_d   = S_FETCH;
`endif
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
        end
    end
endmodule

// File: tb/tb_fetch_decode.sv
// Table-driven bench for fetch_decode (NBITS=8). The bench plays the
// instruction memory, feeding a hand-encoded instruction trace with chosen
// wait states and datapath feedback, and checks every EXEC cycle and the
// following fetch address against hand-computed values.
module tb_fetch_decode;
    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] rs1_w, rs2_w, rd_w;
    logic [7:0] imm_w;
    logic [3:0] aluc_w;
    logic       alusrc_w, memtoreg_w, regwrite_w, link_w, halted_w;
    logic [7:0] pclink_w, instret_w;
    logic [7:0] pcreg;
    logic       zero;

    int n_pass  = 0;
    int n_total = 0;

    fetch_decode_if #(.NBITS(8)) imem_bus ();

    fetch_decode #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem       (imem_bus),
        .RS1        (rs1_w),
        .RS2        (rs2_w),
        .RD         (rd_w),
        .IMM        (imm_w),
        .ALUControl (aluc_w),
        .ALUSrc     (alusrc_w),
        .MemtoReg   (memtoreg_w),
        .RegWrite   (regwrite_w),
        .link       (link_w),
        .pclink     (pclink_w),
        .PCReg      (pcreg),
        .Zero       (zero),
        .halted     (halted_w),
        .instret    (instret_w)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        int          waits;
        logic [7:0]  pcreg;
        logic        zero;
        logic [7:0]  pc;
        logic        chk_rs;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        chk_rd;
        logic [4:0]  rd;
        logic        chk_imm;
        logic [7:0]  imm;
        logic        chk_alu;
        logic [3:0]  aluc;
        logic        alusrc;
        logic        regwrite;
        logic        lnk;
        logic [7:0]  pclink;
        logic [7:0]  next_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Fetch one instruction with the given wait states, then check EXEC.
    task automatic run_vec(input vec_t v, input int exp_instret);
        chk("fetch_req", imem_bus.imem_req, 1'b1);
        chk("fetch_addr", imem_bus.imem_addr, v.pc);
        for (int w = 0; w < v.waits; w++) begin
            imem_bus.imem_ack = 1'b0;
            step();
            chk("wait_req", imem_bus.imem_req, 1'b1);
            chk("wait_addr", imem_bus.imem_addr, v.pc);
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = v.instr;
        pcreg = v.pcreg;
        zero  = v.zero;
        step();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEADBEEF;
        if (v.chk_rs) begin
            chk("exec_rs1", rs1_w, v.rs1);
            chk("exec_rs2", rs2_w, v.rs2);
        end
        if (v.chk_rd) chk("exec_rd", rd_w, v.rd);
        if (v.chk_imm) chk("exec_imm", imm_w, v.imm);
        if (v.chk_alu) begin
            chk("exec_aluc", aluc_w, v.aluc);
            chk("exec_alusrc", alusrc_w, v.alusrc);
        end
        chk("exec_regwrite", regwrite_w, v.regwrite);
        chk("exec_link", link_w, v.lnk);
        chk("exec_pclink", pclink_w, v.pclink);
        chk("exec_halted", halted_w, 1'b0);
        step();
        chk("next_pc", imem_bus.imem_addr, v.next_pc);
        chk("instret", instret_w, exp_instret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //          instr         w  pcreg  z  pc     rs: rs1 rs2  rd:    imm:        alu: op  src rw lnk pclink next
        vecs[0] = '{32'h00500093, 0, 8'h00, 0, 8'h00, 1, 5'd0, 5'd5, 1, 5'd1, 1, 8'h05, 1, 4'h0, 1, 1, 0, 8'h04, 8'h04};
        vecs[1] = '{32'h002081B3, 3, 8'h00, 0, 8'h04, 1, 5'd1, 5'd2, 1, 5'd3, 0, 8'h00, 1, 4'h0, 0, 1, 0, 8'h08, 8'h08};
        vecs[2] = '{32'hFE000CE3, 0, 8'h00, 1, 8'h08, 1, 5'd0, 5'd0, 0, 5'd0, 0, 8'h00, 1, 4'h8, 0, 0, 0, 8'h0C, 8'h00};
        vecs[3] = '{32'h00500093, 1, 8'h00, 0, 8'h00, 1, 5'd0, 5'd5, 1, 5'd1, 1, 8'h05, 1, 4'h0, 1, 1, 0, 8'h04, 8'h04};
        vecs[4] = '{32'h002081B3, 0, 8'h00, 1, 8'h04, 1, 5'd1, 5'd2, 1, 5'd3, 0, 8'h00, 1, 4'h0, 0, 1, 0, 8'h08, 8'h08};
        vecs[5] = '{32'hFE000CE3, 0, 8'h00, 0, 8'h08, 1, 5'd0, 5'd0, 0, 5'd0, 0, 8'h00, 1, 4'h8, 0, 0, 0, 8'h0C, 8'h0C};
        vecs[6] = '{32'h003100E7, 0, 8'h21, 0, 8'h0C, 1, 5'd2, 5'd3, 1, 5'd1, 1, 8'h03, 0, 4'h0, 0, 1, 1, 8'h10, 8'h24};
        vecs[7] = '{32'h0D40006F, 0, 8'h00, 0, 8'h24, 0, 5'd0, 5'd0, 1, 5'd0, 0, 8'h00, 0, 4'h0, 0, 1, 1, 8'h28, 8'hF8};
        vecs[8] = '{32'h010000EF, 1, 8'h00, 0, 8'hF8, 0, 5'd0, 5'd0, 1, 5'd1, 0, 8'h00, 0, 4'h0, 0, 1, 1, 8'hFC, 8'h08};
        vecs[9] = '{32'h40208233, 2, 8'h00, 0, 8'h08, 1, 5'd1, 5'd2, 1, 5'd4, 0, 8'h00, 1, 4'h8, 0, 1, 0, 8'h0C, 8'h0C};

        reset = 1'b1;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        pcreg = 8'h00;
        zero  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_req", imem_bus.imem_req, 1'b0);
        chk("rst_regwrite", regwrite_w, 1'b0);
        chk("rst_link", link_w, 1'b0);
        chk("rst_alusrc", alusrc_w, 1'b0);
        chk("rst_memtoreg", memtoreg_w, 1'b0);
        chk("rst_aluc", aluc_w, 4'h0);
        chk("rst_rd", rd_w, 5'd0);
        chk("rst_halted", halted_w, 1'b0);
        chk("rst_instret", instret_w, 8'd0);
        reset = 1'b0;
        #1;

        // Instruction trace
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i + 1);

        // Illegal word at PC=0x0C
        chk("ill_addr", imem_bus.imem_addr, 8'h0C);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hFFFFFFFF;
        step();
        imem_bus.imem_ack = 1'b0;
        chk("ill_regwrite", regwrite_w, 1'b0);
        chk("ill_link", link_w, 1'b0);
        step();
`ifdef FETCH_HALT_ON_ILLEGAL_EN
        chk("halt_halted", halted_w, 1'b1);
        chk("halt_req", imem_bus.imem_req, 1'b0);
        chk("halt_instret", instret_w, 8'd10);
        imem_bus.imem_ack = 1'b1;
        step();
        step();
        imem_bus.imem_ack = 1'b0;
        chk("halt_stays", halted_w, 1'b1);
        chk("halt_req2", imem_bus.imem_req, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("halt_rst_halted", halted_w, 1'b0);
        chk("halt_rst_addr", imem_bus.imem_addr, 8'h00);
        chk("halt_rst_req", imem_bus.imem_req, 1'b1);
`else
        chk("nop_halted", halted_w, 1'b0);
        chk("nop_addr", imem_bus.imem_addr, 8'h10);
        chk("nop_instret", instret_w, 8'd11);
        chk("nop_req", imem_bus.imem_req, 1'b1);
`endif

        // Reset mid-wait with an ack in the same cycle: ack must be dropped
        imem_bus.imem_ack = 1'b0;
        step();
        chk("midwait_req", imem_bus.imem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("midwait_req_in_reset", imem_bus.imem_req, 1'b0);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h00500093;
        step();
        reset = 1'b0;
        imem_bus.imem_ack = 1'b0;
        #1;
        chk("midwait_rst_req", imem_bus.imem_req, 1'b1);
        chk("midwait_rst_addr", imem_bus.imem_addr, 8'h00);
        chk("midwait_rst_instret", instret_w, 8'd0);
        chk("midwait_rst_regwrite", regwrite_w, 1'b0);

        // Reset during EXEC: controls drop at once, nothing retires
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h00500093;
        step();
        imem_bus.imem_ack = 1'b0;
        chk("exec_pre_regwrite", regwrite_w, 1'b1);
        reset = 1'b1;
        #1;
        chk("exec_rst_regwrite", regwrite_w, 1'b0);
        chk("exec_rst_alusrc", alusrc_w, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("exec_rst_addr", imem_bus.imem_addr, 8'h00);
        chk("exec_rst_instret", instret_w, 8'd0);
        chk("exec_rst_req", imem_bus.imem_req, 1'b1);

        // Normal operation resumes after reset
        run_vec(vecs[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
